// File: rtl/cipher_out_buffer.sv
// cipher_out_buffer: FIFO output stage that buffers finished AES blocks behind a valid/ready handshake
//
// Ports:
//   clk        in   single clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   done       in   one-cycle pulse, data holds a finished block
//   data       in   DATA_W block from the AES core
//   clear      in   synchronous flush of all entries and flags
//   out_ready  in   consumer accepts the head block this cycle
//   out_valid  out  head block is present on cipher
//   cipher     out  head block, first-word-fall-through
//   full       out  count == DEPTH
//   empty      out  count == 0
//   count      out  number of blocks held
//   overflow   out  sticky, a done arrived while full and was dropped
//
// Build option CIPHER_OUT_MASK_EN: when defined, cipher reads all zeros whenever
// out_valid is low; otherwise it holds the last head word while empty.
module cipher_out_buffer #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              done,
  input  logic [DATA_W-1:0] data,
  input  logic              clear,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] cipher,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);
  localparam int PW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [CNT_W-1:0] count_next;
  logic [DATA_W-1:0] head, cipher_next;
  logic push, pop;
  assign full = count == CNT_W'(DEPTH);
  assign empty = count == '0;
  assign out_valid = ~empty;
  assign pop = out_valid & out_ready;
  assign push = done & (~full | pop);
  assign rd_next = rd_ptr + PW'(pop);
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);
  // cipher is registered, so the next head is chosen one cycle early; when the
  // write slot is the next head the storage word is not written yet, so bypass data
  assign head = (push && wr_ptr == rd_next) ? data : mem[rd_next];
`ifdef CIPHER_OUT_MASK_EN
  assign cipher_next = count_next == '0 ? '0 : head;
`else
  assign cipher_next = count_next == '0 ? cipher : head;
`endif
  always_ff @(posedge clk)
    if (push && !clear) mem[wr_ptr] <= data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      cipher <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      cipher <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_next;
      count <= count_next;
      cipher <= cipher_next;
      if (done && !push) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_cipher_out_buffer.sv
// tb_cipher_out_buffer: directed and randomized checks of cipher_out_buffer against a queue model
module tb_cipher_out_buffer;
  localparam int DATA_W = 128;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic done = 1'b0;
  logic [DATA_W-1:0] data = '0;
  logic clear = 1'b0;
  logic out_ready = 1'b0;
  logic out_valid, full, empty, overflow;
  logic [DATA_W-1:0] cipher;
  logic [CNT_W-1:0] count;
  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;
  logic [DATA_W-1:0] m_q[$];
  logic m_ovf = 1'b0;
  logic m_zero = 1'b1;
  cipher_out_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .done(done), .data(data), .clear(clear),
    .out_ready(out_ready), .out_valid(out_valid), .cipher(cipher), .full(full),
    .empty(empty), .count(count), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_zero = 1'b1;
  endtask
  // one clock: apply inputs, let the edge happen, advance the model by the same rules
  task automatic cyc(input logic d, input logic [DATA_W-1:0] dat, input logic clr, input logic rdy);
    logic pp, ps;
    done = d;
    data = dat;
    clear = clr;
    out_ready = rdy;
    @(posedge clk);
    if (!reset_n) model_reset();
    else if (clr) model_reset();
    else begin
      pp = m_q.size() > 0 && rdy;
      ps = d && (m_q.size() < DEPTH || pp);
      if (pp) void'(m_q.pop_front());
      if (ps) begin
        m_q.push_back(dat);
        m_zero = 1'b0;
      end else if (d) m_ovf = 1'b1;
    end
    #1;
  endtask
  always @(negedge clk)
    if (chk_en) begin
      chk("valid", DATA_W'(out_valid), DATA_W'(m_q.size() > 0));
      chk("count", DATA_W'(count), DATA_W'(m_q.size()));
      chk("full", DATA_W'(full), DATA_W'(m_q.size() == DEPTH));
      chk("empty", DATA_W'(empty), DATA_W'(m_q.size() == 0));
      chk("overflow", DATA_W'(overflow), DATA_W'(m_ovf));
      if (m_q.size() > 0) chk("cipher", cipher, m_q[0]);
      else if (m_zero) chk("cipher_zero", cipher, '0);
`ifdef CIPHER_OUT_MASK_EN
      else chk("cipher_mask", cipher, '0);
`endif
    end
  initial begin
    logic [DATA_W-1:0] k;
    k = 128'h3925841d02dc09fbdc118597196a0b32;
    reset_n = 1'b0;
    model_reset();
    repeat (3) cyc(0, '0, 0, 0);
    chk("rst_valid", DATA_W'(out_valid), 0);
    chk("rst_empty", DATA_W'(empty), 1);
    chk("rst_count", DATA_W'(count), 0);
    chk("rst_ovf", DATA_W'(overflow), 0);
    chk("rst_cipher", cipher, 0);
    reset_n = 1'b1;
    chk_en = 1'b1;
    cyc(1, k, 0, 0);
    chk("single_valid", DATA_W'(out_valid), 1);
    chk("single_cipher", cipher, k);
    chk("single_count", DATA_W'(count), 1);
    cyc(0, '0, 0, 1);
    chk("single_empty", DATA_W'(empty), 1);
    for (int i = 1; i <= 5; i++) cyc(1, DATA_W'(i), 0, 0);
    chk("fill_count", DATA_W'(count), 4);
    chk("fill_full", DATA_W'(full), 1);
    chk("fill_ovf", DATA_W'(overflow), 1);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", cipher, DATA_W'(i));
      cyc(0, '0, 0, 1);
    end
    chk("drain_empty", DATA_W'(empty), 1);
    cyc(0, '0, 1, 0);
    chk("clear_ovf", DATA_W'(overflow), 0);
    for (int i = 1; i <= 4; i++) cyc(1, DATA_W'(i), 0, 0);
    cyc(1, DATA_W'(9), 0, 1);
    chk("fullpp_count", DATA_W'(count), 4);
    chk("fullpp_ovf", DATA_W'(overflow), 0);
    for (int i = 0; i < 4; i++) begin
      chk("fullpp_order", cipher, i == 3 ? DATA_W'(9) : DATA_W'(i + 2));
      cyc(0, '0, 0, 1);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1, DATA_W'(i), 0, 1);
      chk("wrap_valid", DATA_W'(out_valid), 1);
      chk("wrap_cipher", cipher, DATA_W'(i));
    end
    cyc(0, '0, 0, 1);
    chk("wrap_empty", DATA_W'(empty), 1);
    cyc(1, DATA_W'(1), 0, 0);
    cyc(1, DATA_W'(2), 0, 0);
    cyc(1, DATA_W'(3), 1, 0);
    chk("clr_count", DATA_W'(count), 0);
    chk("clr_empty", DATA_W'(empty), 1);
    chk("clr_ovf", DATA_W'(overflow), 0);
    chk("clr_cipher", cipher, 0);
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 350) begin
        reset_n = 1'b0;
        model_reset();
        #2 reset_n = 1'b1;
      end
      cyc($urandom_range(0, 99) < 55, {$urandom, $urandom, $urandom, $urandom},
          $urandom_range(0, 99) < 3, $urandom_range(0, 99) < (n % 400 < 200 ? 30 : 70));
    end
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
